// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core store port.
// TXDATA stores feed a small FIFO that a bit-serial FSM drains, and STATUS reports overflow/full/busy.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
    parameter int          CLKS_PER_BIT = 8,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy,
    output logic        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_TICK = BIT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [BIT_W-1:0] tick_q, tick_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic wr_data, wr_status, empty, full, bit_end, pop, push_ok, drop;
    logic unused_bits;

    assign sel         = (addr[31:3] == BASE_ADDR[31:3]);
    assign wr_data     = we & sel & ~addr[2];
    assign wr_status   = we & sel &  addr[2];
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign bit_end     = (tick_q == LAST_TICK);
    assign push_ok     = wr_data & (~full | pop);
    assign drop        = wr_data & full & ~pop;
    assign unused_bits = ^{addr[1:0], wd[31:8]};

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        tick_d    = bit_end ? '0 : tick_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx follows the state being entered so the flop output matches the current state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop)                  overflow_d = 1'b1;
        else if (wr_status & wd[0]) overflow_d = 1'b0;
        else                       overflow_d = overflow_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_q + PTR_W'(push_ok);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
            count_q    <= count_d;
        end
    end

    // NOTE: the FIFO storage has no reset; clearing the pointers and count is enough to empty it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wd[7:0];
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign tx_busy  = (state_q != IDLE) | ~empty;
    assign rdata    = (sel & addr[2]) ? {29'b0, overflow_q, full, tx_busy} : 32'b0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line monitor decodes frames from tx, the stimulus compares them.
module tb_uart_tx_mmio;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic        sel, tx, tx_busy, overflow;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rst_count = 0;

    typedef struct {
        logic [7:0] data;
        logic       framing_ok;
        int         start_cyc;
    } frame_t;
    frame_t rxq[$];

    uart_tx_mmio #(.BASE_ADDR(32'h0000_0400), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .addr(addr), .wd(wd),
        .sel(sel), .rdata(rdata), .tx(tx), .tx_busy(tx_busy), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge reset_n) rst_count <= rst_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Samples each bit mid-cell; frames cut short by a reset are discarded.
    initial begin : monitor
        frame_t f;
        int     r0;
        logic   st;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                r0 = rst_count;
                f.start_cyc = cyc;
                repeat (CPB/2 - 1) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.data[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                f.framing_ok = (st === 1'b0) && (tx === 1'b1);
                if (rst_count == r0) rxq.push_back(f);
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        @(negedge clk);
        we = 1'b0; addr = '0; wd = '0;
    endtask

    task automatic store_burst(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            we = 1'b1; addr = 32'h400; wd = {24'h0, bytes[i]};
            @(negedge clk);
        end
        we = 1'b0; addr = '0; wd = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        addr = 32'h404;
        #1 v = rdata;
        addr = '0;
    endtask

    task automatic wait_frames(input string tag, input int n, input int budget);
        int k = 0;
        while (rxq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(rxq.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (tx_busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(tx_busy), 32'd0);
    endtask

    task automatic check_frames(input string tag, input int base, input logic [7:0] exp[$]);
        foreach (exp[i]) begin
            if (base + i < rxq.size()) begin
                check($sformatf("%s_data%0d", tag, i), 32'(rxq[base+i].data), 32'(exp[i]));
                check($sformatf("%s_frm%0d", tag, i), 32'(rxq[base+i].framing_ok), 32'd1);
            end
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] st;
        int          base, c0;
        logic        saw_low;

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        read_status(st);
        check("rst_status", st, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single 0x55 frame, start bit one cycle after the push, busy lasts 81 edges.
        base = rxq.size();
        store(32'h400, 32'h55);
        c0 = cyc;
        check("t1_tx_hold", 32'(tx), 32'd1);
        check("t1_busy_rise", 32'(tx_busy), 32'd1);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 32'd0);
        wait_idle("t1_idle", 200);
        check("t1_busy_len", 32'(cyc - c0), 32'd81);
        wait_frames("t1_nframes", base + 1, 20);
        check_frames("t1", base, '{8'h55});
        if (rxq.size() > base) check("t1_start_lat", 32'(rxq[base].start_cyc - c0), 32'd1);
        repeat (4) @(negedge clk);

        // 2: two back-to-back frames with no idle gap.
        base = rxq.size();
        store_burst('{8'hA5, 8'h3C});
        wait_frames("t2_nframes", base + 2, 400);
        check_frames("t2", base, '{8'hA5, 8'h3C});
        if (rxq.size() > base + 1)
            check("t2_gap", 32'(rxq[base+1].start_cyc - rxq[base].start_cyc), 32'(10 * CPB));
        wait_idle("t2_idle", 100);
        repeat (4) @(negedge clk);

        // 3: six pushes, the sixth is dropped and flags overflow.
        base = rxq.size();
        store_burst('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        read_status(st);
        check("t3_status_full", st, 32'h7);
        check("t3_ovf_pin", 32'(overflow), 32'd1);
        wait_frames("t3_nframes", base + 5, 700);
        wait_idle("t3_idle", 100);
        repeat (20) @(negedge clk);
        check("t3_no_sixth", 32'(rxq.size()), 32'(base + 5));
        check_frames("t3", base, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
        read_status(st);
        check("t3_status_idle", st, 32'h4);
        store(32'h404, 32'h2);
        read_status(st);
        check("t3_clear_bit1", st, 32'h4);
        store(32'h404, 32'h1);
        read_status(st);
        check("t3_clear", st, 32'h0);

        // 4: decode boundaries and a store outside the window.
        base = rxq.size();
        addr = 32'd100;      #1 check("t4_sel_dmem", 32'(sel), 32'd0);
        check("t4_rd_dmem", rdata, 32'h0);
        addr = 32'h400;      #1 check("t4_sel_tx", 32'(sel), 32'd1);
        check("t4_rd_txdata", rdata, 32'h0);
        addr = 32'h407;      #1 check("t4_sel_top", 32'(sel), 32'd1);
        addr = 32'h408;      #1 check("t4_sel_above", 32'(sel), 32'd0);
        addr = 32'h3FC;      #1 check("t4_sel_below", 32'(sel), 32'd0);
        addr = '0;
        @(negedge clk);
        store(32'd100, 32'd25);
        check("t4_busy", 32'(tx_busy), 32'd0);
        saw_low = 1'b0;
        repeat (3 * CPB) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("t4_tx_idle", 32'(saw_low), 32'd0);
        check("t4_no_frame", 32'(rxq.size()), 32'(base));

        // 5: reset during data bit 3 with two bytes still queued.
        base = rxq.size();
        store_burst('{8'h81, 8'h42, 8'h24});
        repeat (34) @(negedge clk);
        read_status(st);
        check("t5_pre_status", st, 32'h1);
        #1 reset_n = 1'b0;
        #1 check("t5_tx_async", 32'(tx), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        read_status(st);
        check("t5_status", st, 32'h0);
        repeat (30 * CPB) @(negedge clk);
        check("t5_no_frames", 32'(rxq.size()), 32'(base));
        check("t5_tx_high", 32'(tx), 32'd1);

        // 6: push lands on the same edge the FSM pops from a full FIFO.
        base = rxq.size();
        store_burst('{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5});
        read_status(st);
        check("t6_full", st, 32'h3);
        repeat (76) @(negedge clk);
        store(32'h400, 32'hF6);
        check("t6_no_ovf", 32'(overflow), 32'd0);
        read_status(st);
        check("t6_still_full", st, 32'h3);
        wait_frames("t6_nframes", base + 6, 700);
        check_frames("t6", base, '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hF6});
        wait_idle("t6_idle", 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
